// File: rtl/reg_mem_2r1w.sv
// Two-read / one-write register file with per-bit write mask, write-first
// read bypass, asynchronous reset of all entries and a hardware clear sweep.
module reg_mem_2r1w #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_BITS  = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_BITS-1:0]  waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] wmask_i,
    input  logic                  wen_i,
    input  logic [ADDR_BITS-1:0]  raddr_a_i,
    input  logic                  ren_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic [ADDR_BITS-1:0]  raddr_b_i,
    input  logic                  ren_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    input  logic                  clr_i,
    output logic                  busy_o,
    output logic                  wr_drop_o
);
    localparam int                   DEPTH    = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] PTR_LAST = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_a_q, rdata_b_q;
    logic                  wr_drop_q;

    logic                  busy_s;
    logic                  wr_en_s;
    logic [ADDR_BITS-1:0]  wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_val_s;
    logic [DATA_WIDTH-1:0] rd_a_s, rd_b_s;

    assign busy_s    = (state_q == ST_CLEAR);
    assign busy_o    = busy_s;
    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;
    assign wr_drop_o = wr_drop_q;

    // Sweep state machine: next state and pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d   = ptr_q + PTR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Single write source: the sweep owns the port while busy, user writes otherwise.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = waddr_i;
        wr_val_s  = RESET_VAL;
        if (busy_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = ptr_q;
            wr_val_s  = RESET_VAL;
        end else if (wen_i) begin
            wr_en_s   = 1'b1;
            wr_addr_s = waddr_i;
            wr_val_s  = (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Write-first read data: a same-edge write to the read address wins.
    always_comb begin
        rd_a_s = mem_q[raddr_a_i];
        rd_b_s = mem_q[raddr_b_i];
        if (wr_en_s && (wr_addr_s == raddr_a_i)) begin
            rd_a_s = wr_val_s;
        end else begin
            rd_a_s = mem_q[raddr_a_i];
        end
        if (wr_en_s && (wr_addr_s == raddr_b_i)) begin
            rd_b_s = wr_val_s;
        end else begin
            rd_b_s = mem_q[raddr_b_i];
        end
    end

    // Control registers: FSM state, sweep pointer, drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wen_i & busy_s;
        end
    end

    // Storage array; reset loads every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_val_s;
        end
    end

    // Registered read ports; data holds while the port is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (ren_a_i) begin
                rdata_a_q <= rd_a_s;
            end
            if (ren_b_i) begin
                rdata_b_q <= rd_b_s;
            end
        end
    end

endmodule

// File: tb/tb_reg_mem_2r1w.sv
// Self-checking bench for reg_mem_2r1w: constant-expectation vector table plus
// a reference model feeding a scoreboard queue for the multi-cycle sequences.
module tb_reg_mem_2r1w;
    logic       clk;
    logic       rst_n;
    logic [4:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata, wmask, rdata_a, rdata_b;
    logic       wen, ren_a, ren_b, clr, busy, wr_drop;

    reg_mem_2r1w #(.DATA_WIDTH(8), .ADDR_BITS(5), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .waddr_i(waddr), .wdata_i(wdata), .wmask_i(wmask), .wen_i(wen),
        .raddr_a_i(raddr_a), .ren_a_i(ren_a), .rdata_a_o(rdata_a),
        .raddr_b_i(raddr_b), .ren_b_i(ren_b), .rdata_b_o(rdata_b),
        .clr_i(clr), .busy_o(busy), .wr_drop_o(wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       busy;
        logic       drop;
    } exp_t;

    typedef struct {
        logic       we;
        logic [4:0] wa;
        logic [7:0] wd;
        logic [7:0] wm;
        logic       rea;
        logic [4:0] ra;
        logic       reb;
        logic [4:0] rb;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[8];
    int         checks = 0;
    int         errors = 0;

    logic [7:0] m_mem[32];
    logic       m_busy;
    logic [4:0] m_ptr;
    logic [7:0] m_a, m_b;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
        m_busy = 1'b0;
        m_ptr  = 5'd0;
        m_a    = 8'h00;
        m_b    = 8'h00;
        sb_q.delete();
    endtask

    // One clock: drive, advance the model, push expectation, then pop and compare.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                         input logic [7:0] wm, input logic rea, input logic [4:0] ra,
                         input logic reb, input logic [4:0] rb, input logic c);
        exp_t       e;
        logic       wr;
        logic [4:0] wadr;
        logic [7:0] wv;
        wen = we; waddr = wa; wdata = wd; wmask = wm;
        ren_a = rea; raddr_a = ra; ren_b = reb; raddr_b = rb; clr = c;
        wr   = m_busy | we;
        wadr = m_busy ? m_ptr : wa;
        wv   = m_busy ? 8'h00 : ((m_mem[wa] & ~wm) | (wd & wm));
        if (rea) m_a = (wr && ra == wadr) ? wv : m_mem[ra];
        if (reb) m_b = (wr && rb == wadr) ? wv : m_mem[rb];
        e.drop = we & m_busy;
        if (wr) m_mem[wadr] = wv;
        if (m_busy) begin
            if (m_ptr == 5'd31) begin
                m_busy = 1'b0;
                m_ptr  = 5'd0;
            end else begin
                m_ptr = m_ptr + 5'd1;
            end
        end else if (c) begin
            m_busy = 1'b1;
            m_ptr  = 5'd0;
        end
        e.a = m_a; e.b = m_b; e.busy = m_busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("rdata_a", rdata_a, e.a);
        chk("rdata_b", rdata_b, e.b);
        chk("busy", {7'd0, busy}, {7'd0, e.busy});
        chk("wr_drop", {7'd0, wr_drop}, {7'd0, e.drop});
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 8'h00, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++)
            cycle(1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 5'(i), 1'b1, 5'(31 - i), 1'b0);
    endtask

    task automatic wait_sweep_end(output int cnt);
        cnt = busy ? 1 : 0;
        for (int k = 0; k < 40 && busy; k++) begin
            idle();
            if (busy) cnt++;
        end
    endtask

    int busy_cnt;

    initial begin
        rst_n = 1'b0; wen = 1'b0; waddr = 5'd0; wdata = 8'h00; wmask = 8'h00;
        ren_a = 1'b0; raddr_a = 5'd0; ren_b = 1'b0; raddr_b = 5'd0; clr = 1'b0;
        model_reset();

        vecs[0] = '{1'b1, 5'd12, 8'hFF, 8'hFF, 1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 8'h00};
        vecs[1] = '{1'b1, 5'd12, 8'h00, 8'h0F, 1'b0, 5'd0,  1'b0, 5'd0,  8'h00, 8'h00};
        vecs[2] = '{1'b0, 5'd0,  8'h00, 8'h00, 1'b1, 5'd12, 1'b1, 5'd13, 8'hF0, 8'h00};
        vecs[3] = '{1'b1, 5'd3,  8'h11, 8'hFF, 1'b0, 5'd0,  1'b0, 5'd0,  8'hF0, 8'h00};
        vecs[4] = '{1'b1, 5'd3,  8'h5A, 8'hFF, 1'b1, 5'd3,  1'b1, 5'd3,  8'h5A, 8'h5A};
        vecs[5] = '{1'b0, 5'd0,  8'h00, 8'h00, 1'b1, 5'd12, 1'b0, 5'd3,  8'hF0, 8'h5A};
        vecs[6] = '{1'b1, 5'd7,  8'hAB, 8'h00, 1'b1, 5'd7,  1'b1, 5'd12, 8'h00, 8'hF0};
        vecs[7] = '{1'b1, 5'd12, 8'h0C, 8'h3C, 1'b1, 5'd12, 1'b1, 5'd3,  8'hCC, 8'h5A};

        // Reset released mid-cycle
        #23 rst_n = 1'b1;
        #1;
        chk("reset_rdata_a", rdata_a, 8'h00);
        chk("reset_rdata_b", rdata_b, 8'h00);
        chk("reset_busy", {7'd0, busy}, 8'h00);
        chk("reset_wr_drop", {7'd0, wr_drop}, 8'h00);
        read_all();

        // Table: masked writes, bypass, dual read, hold
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wm,
                  vecs[i].rea, vecs[i].ra, vecs[i].reb, vecs[i].rb, 1'b0);
            chk($sformatf("vec%0d_a", i), rdata_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_b", i), rdata_b, vecs[i].exp_b);
        end

        // Clear sweep with a dropped write
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 5'(i), 8'(10 + i), 8'hFF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 8'h00, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        busy_cnt = busy ? 1 : 0;
        idle();
        if (busy) busy_cnt++;
        cycle(1'b1, 5'd5, 8'hEE, 8'hFF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        if (busy) busy_cnt++;
        chk("drop_pulse", {7'd0, wr_drop}, 8'h01);
        idle();
        if (busy) busy_cnt++;
        chk("drop_one_cycle", {7'd0, wr_drop}, 8'h00);
        for (int k = 0; k < 40 && busy; k++) begin
            idle();
            if (busy) busy_cnt++;
        end
        chk("busy_cycles", 8'(busy_cnt), 8'd32);
        cycle(1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 5'd5, 1'b1, 5'd31, 1'b0);
        chk("addr5_after_sweep", rdata_a, 8'h00);
        read_all();

        // Clear with concurrent write; read of entry 0 on the first sweep edge
        cycle(1'b1, 5'd0, 8'h99, 8'hFF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle(1'b1, 5'd31, 8'h77, 8'hFF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        cycle(1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 5'd0, 1'b1, 5'd31, 1'b0);
        chk("sweep_first_a0", rdata_a, 8'h00);
        chk("sweep_b31_pre", rdata_b, 8'h77);
        wait_sweep_end(busy_cnt);
        cycle(1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
        chk("addr31_after_sweep", rdata_a, 8'h00);

        // Reset mid-sweep
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 5'(20 + i), 8'h80 | 8'(i), 8'hFF, 1'b1, 5'(i), 1'b0, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 8'h00, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 9; i++) idle();
        chk("busy_before_reset", {7'd0, busy}, 8'h01);
        #3 rst_n = 1'b0;
        #1;
        chk("busy_async_drop", {7'd0, busy}, 8'h00);
        chk("rdata_a_async_rst", rdata_a, 8'h00);
        model_reset();
        #2 rst_n = 1'b1;
        cycle(1'b1, 5'd4, 8'h3C, 8'hFF, 1'b1, 5'd4, 1'b1, 5'd25, 1'b0);
        chk("post_reset_write", rdata_a, 8'h3C);
        chk("post_reset_b25", rdata_b, 8'h00);
        read_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/reg_mem_2r1w.md
Name: reg_mem_2r1w

Overview:
Parametrised register-file memory: one write port, two independent registered read ports. Adds per-bit write masking, write-first read bypass, asynchronous reset of all contents, and a hardware clear sweep with a busy flag. Used wherever the datapath needs two operands per cycle from a small register store.

Parameters:
DATA_WIDTH, 8, width of each entry in bits
ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS entries, all addresses valid
RESET_VAL, 0, value (DATA_WIDTH bits) loaded into every entry by reset and by the clear sweep

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
waddr  in  ADDR_BITS  write address
wdata  in  DATA_WIDTH  write data
wmask  in  DATA_WIDTH  per-bit write enable; 1 = bit written
wen  in  1  write request
raddr_a  in  ADDR_BITS  read port A address
ren_a  in  1  read port A enable
rdata_a  out  DATA_WIDTH  read port A data, registered
raddr_b  in  ADDR_BITS  read port B address
ren_b  in  1  read port B enable
rdata_b  out  DATA_WIDTH  read port B data, registered
clr  in  1  start clear sweep (sampled, level, acted on only in IDLE)
busy  out  1  high while clear sweep in progress
wr_drop  out  1  one-cycle pulse: write request rejected because busy

Behaviour:
- Reset (rst_n low, asynchronous): all entries = RESET_VAL; rdata_a = rdata_b = 0; busy = 0; wr_drop = 0; state IDLE; sweep pointer 0. Reset mid-sweep aborts the sweep immediately.
- Write: at a rising edge with wen=1 and busy=0: mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask). wmask all-zero leaves the entry unchanged (still counts as accepted).
- Write while busy=1: ignored, memory unchanged; wr_drop = 1 for the following cycle. Otherwise wr_drop = 0.
- Read: latency 1. At a rising edge with ren_x=1, rdata_x <= mem[raddr_x]; with ren_x=0, rdata_x holds. Ports fully independent; both may read the same address.
- Bypass (write-first): if an accepted write and a read hit the same address on the same edge, rdata_x gets the merged post-write value.
- State machine, two states:
  - IDLE: busy=0. clr=1 at an edge -> CLEAR, pointer=0. A wen in that same edge is still accepted and is later overwritten by the sweep.
  - CLEAR: busy=1. Each edge writes RESET_VAL to mem[pointer] and increments pointer. On the edge where pointer = DEPTH-1 the last entry is cleared -> IDLE, pointer=0.
  - busy is high for exactly DEPTH cycles. clr is ignored during CLEAR; no restart.
- Reads during CLEAR are allowed and return current contents. A read of the entry being cleared on that edge returns RESET_VAL (bypass applies to sweep writes).
- Pointer wrap: the pointer is ADDR_BITS wide; the end condition is pointer = DEPTH-1, never overflow detection.

Test Plan:
- Reset: pulse rst_n low mid-cycle with defaults -> rdata_a=rdata_b=0x00, busy=0, and reading addresses 0..31 on both ports returns 0x00.
- Masked write: write 0xFF to address 12 with mask 0xFF, then 0x00 with mask 0x0F -> read next cycle on A returns 0xF0; B reading address 13 returns 0x00.
- Bypass plus dual read: address 3 = 0x11; same edge write 0x5A mask 0xFF to address 3, A reads 3, B reads 3 -> both show 0x5A one cycle later; with ren_b=0, rdata_b holds its previous value.
- Clear sweep: fill addresses 0..31 with 10..41; pulse clr -> busy high exactly 32 cycles. A wen to address 5 during busy -> wr_drop pulses once and address 5 stays 0x00 after sweep; all entries then read 0x00.
- Clear with concurrent write: clr=1 and wen to address 31 with 0x77 on the same edge -> after the sweep, address 31 reads 0x00. A read of address 0 on the first sweep edge returns 0x00.
- Reset mid-sweep: assert rst_n low 10 cycles into the sweep -> busy drops immediately; after release all entries = RESET_VAL and new writes are accepted on the first edge.
